reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; depth is 2**ADDR_W.
REQ-003 Parameter RD_PORTS, default 2, number of read ports; legal range is 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads 0, ignores writes and is never busy.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 RdAddr  in  RD_PORTS*ADDR_W  read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-009 RdData  out  RD_PORTS*DATA_W  read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-010 RdBusy  out  RD_PORTS  port p's register has a pending (unwritten) result.
REQ-011 WrEn  in  1  writeback strobe.
REQ-012 WrAddr  in  ADDR_W  writeback index.
REQ-013 WrData  in  DATA_W  writeback data.
REQ-014 IssueValid  in  1  instruction issue request reserving a destination.
REQ-015 IssueDest  in  ADDR_W  destination index to reserve.
REQ-016 IssueReady  out  1  issue can be accepted this cycle.
REQ-017 BusyCount  out  ADDR_W+1  number of currently busy entries.

Function
REQ-018 Storage SHALL be 2**ADDR_W entries of DATA_W bits, written on the rising clk edge when WrEn=1, with no intra-cycle delay.
REQ-019 Reads SHALL be combinational: RdData[p] = entry[RdAddr[p]].
REQ-020 With BYPASS=1, WrEn=1 and WrAddr==RdAddr[p] SHALL give RdData[p]=WrData and RdBusy[p]=0 in the same cycle.
REQ-021 With ZERO_REG=1, index 0 SHALL read 0 on every port, writes to it SHALL be discarded and it SHALL never be forwarded, reserved or busy.
REQ-022 A per-entry busy bit SHALL be set on the edge where IssueValid & IssueReady and cleared on the edge where WrEn=1 to that index.
REQ-023 IssueReady SHALL be 1 iff busy[IssueDest]=0, or WrEn=1 with WrAddr==IssueDest (WAW-safe same-cycle release).
REQ-024 Simultaneous accepted issue and writeback to the same index SHALL leave busy=1, because the issue wins.
REQ-025 An issue to index 0 with ZERO_REG=1 SHALL have IssueReady=1 and no state effect.
REQ-026 IssueReady SHALL depend only on IssueDest, busy state and the write port; it SHALL NOT depend on IssueValid.
REQ-027 RdBusy[p] SHALL equal busy[RdAddr[p]], except when overridden per REQ-020 or REQ-021.
REQ-028 A writeback to a non-busy index SHALL update data and leave busy=0.
REQ-029 BusyCount SHALL be a registered count equal to the number of busy bits after each edge: +1 on set only, -1 on clear only, unchanged when both or neither occur.
REQ-030 BusyCount SHALL NOT wrap; it SHALL saturate at 2**ADDR_W and at 0.
REQ-031 Multiple read ports addressing the same index SHALL return identical values.

Reset
REQ-032 rst_n=0 SHALL immediately clear all entries to 0, all busy bits to 0 and BusyCount to 0, independent of clk.
REQ-033 While rst_n=0, writes and issues SHALL be ignored; outputs SHALL reflect the cleared state, so IssueReady=1 and RdData=0.
REQ-034 Reset asserted mid-operation SHALL discard all pending reservations; the first edge after deassertion SHALL behave as from empty.

Verification
REQ-035 After reset, write 0xDEADBEEF to r5, then read r5 on port 0 and r0 on port 1 -> 0xDEADBEEF and 0x00000000, RdBusy=00.
REQ-036 Write r7=0x12345678 with RdAddr[0]=7 in the same cycle -> RdData[0]=0x12345678, RdBusy[0]=0 before the edge (BYPASS=1).
REQ-037 Issue r3 -> next cycle RdBusy=1 for r3, IssueReady=0 for IssueDest=3, BusyCount=1; write r3 -> busy clears, BusyCount=0.
REQ-038 r4 busy; same cycle WrEn to r4 with an issue to r4 -> IssueReady=1, r4 stays busy, BusyCount stays 1, data updated.
REQ-039 Issue r1, r2 and r9, pulse rst_n low between edges -> BusyCount=0 and all entries 0 immediately, IssueReady=1 for r1.
REQ-040 Write 0xFFFFFFFF to r0 and issue r0 -> r0 reads 0, RdBusy=0, BusyCount unchanged.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with a per-entry busy scoreboard and a busy count.
// Reads are combinational; a same-cycle write is forwarded to the read ports, and an issue accepted together with a write to the same entry leaves that entry busy.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0]   RdAddr,
  output logic [RD_PORTS*DATA_W-1:0]   RdData,
  output logic [RD_PORTS-1:0]          RdBusy,
  input  logic                         WrEn,
  input  logic [ADDR_W-1:0]            WrAddr,
  input  logic [DATA_W-1:0]            WrData,
  input  logic                         IssueValid,
  input  logic [ADDR_W-1:0]            IssueDest,
  output logic                         IssueReady,
  output logic [ADDR_W:0]              BusyCount
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic wr_ok, iss_zero, set, inc, dec;
  // Gating with rst_n keeps forwarded data off the read ports while reset is held.
  assign wr_ok      = WrEn && rst_n && !(ZERO_REG != 0 && WrAddr == '0);
  assign iss_zero   = ZERO_REG != 0 && IssueDest == '0;
  assign IssueReady = iss_zero || !busy[IssueDest] || (WrEn && WrAddr == IssueDest);
  assign set        = IssueValid && IssueReady && !iss_zero;
  assign inc        = set && !busy[IssueDest];
  assign dec        = wr_ok && busy[WrAddr] && !(set && IssueDest == WrAddr);
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[WrAddr] = 1'b0;
    if (set) busy_nxt[IssueDest] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      if (wr_ok) mem[WrAddr] <= WrData;
      busy <= busy_nxt;
      if (inc && !dec && BusyCount != FULL) BusyCount <= BusyCount + 1'b1;
      else if (dec && !inc && BusyCount != '0) BusyCount <= BusyCount - 1'b1;
    end
  end
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic zero, fwd;
    assign ra   = RdAddr[p*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && ra == '0;
    assign fwd  = BYPASS != 0 && wr_ok && WrAddr == ra;
    assign RdData[p*DATA_W +: DATA_W] = zero ? '0 : fwd ? WrData : mem[ra];
    assign RdBusy[p] = zero ? 1'b0 : fwd ? 1'b0 : busy[ra];
  end
endmodule
